// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: pipelined one-per-cycle fetch into a small FIFO,
// with space reserved at issue time and redirect/reset flushing everything.
module instr_fetch_queue #(
  parameter int WORD_SIZE = 16,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 readM1,
  output logic [WORD_SIZE-1:0] address1,
  input  logic [WORD_SIZE-1:0] data1,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 instr_valid,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] instr_pc,
  input  logic                 instr_ready
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH, FULL} state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] pend_pc_q, pend_pc_d;
  logic                 pend_q, pend_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WORD_SIZE-1:0] word_q [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0] pc_q [QUEUE_DEPTH];

  logic issue;
  logic push;
  logic pop;

  assign issue = reset_n && (state_q == FETCH) && !redirect;
  assign push  = pend_q && !redirect;
  assign pop   = (count_q != '0) && instr_ready && !redirect;

  assign readM1      = reset_n && (issue || pend_q);
  assign address1    = fetch_pc_q;
  assign instr_valid = reset_n && (count_q != '0);
  assign instr       = word_q[head_q];
  assign instr_pc    = pc_q[head_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pend_d     = pend_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    state_d    = state_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      pend_d     = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      pend_d = issue;
      if (issue) begin
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 1'b1;
      end
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    // Occupancy includes the in-flight request so a landing word always fits.
    state_d = ((count_d + CW'(pend_d)) == CW'(QUEUE_DEPTH)) ? FULL : FETCH;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pend_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_q     <= pend_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      word_q[tail_q] <= data1;
      pc_q[tail_q]   <= pend_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed tables/sequences plus a randomized
// run checked against an in-order instruction stream model.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        readM1;
  logic [15:0] address1;
  logic [15:0] data1;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  instr_fetch_queue dut (
    .clk(clk), .reset_n(reset_n),
    .readM1(readM1), .address1(address1), .data1(data1),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    case (a)
      16'h0000: mem_f = 16'h9023;
      16'h0001: mem_f = 16'h0001;
      16'h0023: mem_f = 16'h6000;
      default:  mem_f = {a[7:0], a[15:8]} ^ 16'h5A3C;
    endcase
  endfunction

  logic [15:0] rd_addr = '0;
  always @(posedge clk) if (readM1) rd_addr <= address1;
  assign data1 = readM1 ? mem_f(rd_addr) : 16'hDEAD;

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    tick();
    #1;
    chk("reset_readM1", 16'(readM1), 16'h0);
    chk("reset_valid", 16'(instr_valid), 16'h0);
    tick();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        erd;
    logic        ca;
    logic [15:0] ea;
    logic        ev;
    logic [15:0] epc;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] last_rpc;
    bit          chk_redir;
    int          pops;
    int          r;

    // backpressure, single pop, then redirect without a pending request
    tbl[0]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h1};
    tbl[8]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1};
    tbl[10] = '{1'b1, 1'b1, 16'h23, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1};
    tbl[11] = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0023, 1'b0, 16'h0};
    tbl[12] = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0024, 1'b0, 16'h0};
    tbl[13] = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0025, 1'b1, 16'h23};
    tbl[14] = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0026, 1'b1, 16'h24};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      instr_ready = tbl[i].rdy;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("tbl%0d_readM1", i), 16'(readM1), 16'(tbl[i].erd));
      if (tbl[i].ca) chk($sformatf("tbl%0d_addr", i), address1, tbl[i].ea);
      chk($sformatf("tbl%0d_valid", i), 16'(instr_valid), 16'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), instr, mem_f(tbl[i].epc));
      end
      tick();
    end
    redirect = 1'b0;

    // boot stream, then redirect while a request is in flight
    do_reset();
    instr_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("boot_readM1", 16'(readM1), 16'h1);
      chk("boot_addr", address1, 16'(c));
      chk("boot_valid", 16'(instr_valid), 16'(c >= 2));
      if (c >= 2) begin
        chk("boot_pc", instr_pc, 16'(c - 2));
        chk("boot_instr", instr, mem_f(16'(c - 2)));
      end
      tick();
    end
    redirect = 1'b1;
    redirect_pc = 16'h0023;
    #1;
    chk("redir_pend_readM1", 16'(readM1), 16'h1);
    tick();
    redirect = 1'b0;
    #1;
    chk("redir_n1_valid", 16'(instr_valid), 16'h0);
    chk("redir_n1_readM1", 16'(readM1), 16'h1);
    chk("redir_n1_addr", address1, 16'h0023);
    tick();
    #1;
    chk("redir_n2_valid", 16'(instr_valid), 16'h0);
    tick();
    #1;
    chk("redir_n3_valid", 16'(instr_valid), 16'h1);
    chk("redir_n3_instr", instr, 16'h6000);
    chk("redir_n3_pc", instr_pc, 16'h0023);
    tick();

    // redirect and pop in the same cycle with three queued
    do_reset();
    repeat (4) tick();
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    chk("rp_valid_before", 16'(instr_valid), 16'h1);
    tick();
    redirect = 1'b0;
    #1;
    chk("rp_valid_n1", 16'(instr_valid), 16'h0);
    tick();
    #1;
    chk("rp_valid_n2", 16'(instr_valid), 16'h0);
    tick();
    #1;
    chk("rp_valid_n3", 16'(instr_valid), 16'h1);
    chk("rp_pc_n3", instr_pc, 16'h0040);
    chk("rp_instr_n3", instr, mem_f(16'h0040));
    tick();

    // address wrap
    do_reset();
    instr_ready = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    #1;
    chk("wrap_addr0", address1, 16'hFFFF);
    chk("wrap_rd0", 16'(readM1), 16'h1);
    tick();
    #1;
    chk("wrap_addr1", address1, 16'h0000);
    chk("wrap_rd1", 16'(readM1), 16'h1);
    tick();
    #1;
    chk("wrap_pc0", instr_pc, 16'hFFFF);
    tick();
    #1;
    chk("wrap_pc1", instr_pc, 16'h0000);
    tick();

    // reset in the middle of operation
    do_reset();
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", 16'(instr_valid), 16'h0);
    chk("mrst_readM1", 16'(readM1), 16'h0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("mrst_c0_rd", 16'(readM1), 16'h1);
    chk("mrst_c0_addr", address1, 16'h0000);
    chk("mrst_c0_valid", 16'(instr_valid), 16'h0);
    tick();
    tick();
    #1;
    chk("mrst_c2_pc", instr_pc, 16'h0000);
    chk("mrst_c2_instr", instr, 16'h9023);
    tick();

    // random run: delivered stream must be consecutive from last restart
    do_reset();
    exp_pc = 16'h0000;
    chk_redir = 1'b0;
    last_rpc = '0;
    pops = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      reset_n = (r >= 2);
      redirect = (r >= 2 && r < 7);
      redirect_pc = 16'($urandom);
      instr_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (!reset_n) begin
        chk("rnd_rst_rd", 16'(readM1), 16'h0);
        chk("rnd_rst_valid", 16'(instr_valid), 16'h0);
      end else begin
        if (chk_redir) begin
          chk("rnd_redir_valid", 16'(instr_valid), 16'h0);
          if (!redirect) begin
            chk("rnd_redir_rd", 16'(readM1), 16'h1);
            chk("rnd_redir_addr", address1, last_rpc);
          end
        end
        if (!redirect && instr_valid && instr_ready) begin
          chk("rnd_pc", instr_pc, exp_pc);
          chk("rnd_instr", instr, mem_f(exp_pc));
          exp_pc = exp_pc + 16'h1;
          pops++;
        end
      end
      if (!reset_n) begin
        exp_pc = 16'h0000;
        chk_redir = 1'b0;
      end else if (redirect) begin
        exp_pc = redirect_pc;
        last_rpc = redirect_pc;
        chk_redir = 1'b1;
      end else begin
        chk_redir = 1'b0;
      end
      tick();
    end
    chk("rnd_progress", 16'(pops > 300), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
